// File: rtl/smi_mem_fuzz_campaign_ctrl_pkg.sv
// Shared state encoding and helpers for the fuzz campaign sequencer.
// State is exposed on the top-level dbgState port for checkers.
package smi_mem_fuzz_campaign_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACCUM  = 3'd4,
        ST_REPORT = 3'd5
    } campState_t;

    // Sliced down to the region index width where used.
    localparam logic [63:0] FIRST_FAIL_NONE = '1;

    function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/smi_mem_fuzz_campaign_accum.sv
// Per-campaign result accumulator: saturating error total, wrapping data
// total, failing-region count and first-failing-region capture.
module smi_mem_fuzz_campaign_accum
    import smi_mem_fuzz_campaign_ctrl_pkg::*;
#(
    parameter int RegionIdxWidth = 16
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      clear,
    input  logic                      update,
    input  logic [31:0]               errCount,
    input  logic [63:0]               dataCount,
    input  logic [RegionIdxWidth-1:0] rgnIdx,
    output logic [31:0]               errTotal,
    output logic [63:0]               dataTotal,
    output logic [RegionIdxWidth-1:0] failRegions,
    output logic [RegionIdxWidth-1:0] firstFail
);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            errTotal    <= '0;
            dataTotal   <= '0;
            failRegions <= '0;
            firstFail   <= '0;
        end else if (clear) begin
            errTotal    <= '0;
            dataTotal   <= '0;
            failRegions <= '0;
            firstFail   <= FIRST_FAIL_NONE[RegionIdxWidth-1:0];
        end else if (update) begin
            errTotal  <= satAdd32(errTotal, errCount);
            dataTotal <= dataTotal + dataCount;
            if (errCount != '0) begin
                failRegions <= failRegions + RegionIdxWidth'(1);
                // Zero failures so far means this region is the first one.
                if (failRegions == '0) begin
                    firstFail <= rgnIdx;
                end
            end
        end
    end

endmodule

// File: rtl/smi_mem_fuzz_campaign_ctrl.sv
// Campaign sequencer: splits a memory window into equal regions, runs one
// fuzz configuration per region and reports one aggregated result.
module smi_mem_fuzz_campaign_ctrl
    import smi_mem_fuzz_campaign_ctrl_pkg::*;
#(
    parameter int RegionIdxWidth = 16,
    parameter bit StopOnError    = 1'b0
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      campValid,
    input  logic [63:0]               campAddrBase,
    input  logic [31:0]               campRegionSize,
    input  logic [RegionIdxWidth-1:0] campNumRegions,
    input  logic [31:0]               campTestsPerRgn,
    output logic                      campStop,
    output logic                      configValid,
    output logic [63:0]               configMemAddrBase,
    output logic [31:0]               configMemBlockSize,
    output logic [31:0]               configNumTests,
    input  logic                      configStop,
    input  logic                      statusValid,
    input  logic [31:0]               statusErrorCount,
    input  logic [63:0]               statusDataCount,
    output logic                      statusStop,
    output logic                      resValid,
    output logic [31:0]               resErrorTotal,
    output logic [63:0]               resDataTotal,
    output logic [RegionIdxWidth-1:0] resFailRegions,
    output logic [RegionIdxWidth-1:0] resFirstFail,
    output logic [RegionIdxWidth-1:0] resRegionsRun,
    input  logic                      resStop,
    output campState_t                dbgState
);

    localparam int RIW = RegionIdxWidth;

    // Every handshake transfers on a cycle with valid=1 and stop=0; a raised
    // valid holds with a stable payload until that cycle.
    campState_t     state;
    logic [63:0]    curAddr;
    logic [31:0]    regionSize;
    logic [31:0]    testsPerRgn;
    logic [RIW-1:0] numRegions;
    logic [RIW-1:0] rgnIdx;
    logic [31:0]    stErr;
    logic [63:0]    stData;
    logic           campXfer;
    logic           cfgXfer;
    logic           stXfer;
    logic           resXfer;
    logic [RIW-1:0] rgnNext;

    assign campXfer = campValid && !campStop;
    assign cfgXfer  = configValid && !configStop;
    assign stXfer   = statusValid && !statusStop;
    assign resXfer  = resValid && !resStop;
    assign rgnNext  = rgnIdx + RIW'(1);

    assign configMemAddrBase  = curAddr;
    assign configMemBlockSize = regionSize;
    assign configNumTests     = testsPerRgn;
    assign resRegionsRun      = rgnIdx;
    assign dbgState           = state;

    smi_mem_fuzz_campaign_accum #(
        .RegionIdxWidth(RIW)
    ) u_accum (
        .clk        (clk),
        .arstn      (arstn),
        .clear      ((state == ST_IDLE) && campXfer),
        .update     (state == ST_ACCUM),
        .errCount   (stErr),
        .dataCount  (stData),
        .rgnIdx     (rgnIdx),
        .errTotal   (resErrorTotal),
        .dataTotal  (resDataTotal),
        .failRegions(resFailRegions),
        .firstFail  (resFirstFail)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state       <= ST_RESET;
            campStop    <= 1'b1;
            configValid <= 1'b0;
            statusStop  <= 1'b1;
            resValid    <= 1'b0;
            curAddr     <= '0;
            regionSize  <= '0;
            testsPerRgn <= '0;
            numRegions  <= '0;
            rgnIdx      <= '0;
            stErr       <= '0;
            stData      <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    state    <= ST_IDLE;
                    campStop <= 1'b0;
                end
                ST_IDLE: begin
                    if (campXfer) begin
                        campStop    <= 1'b1;
                        curAddr     <= campAddrBase;
                        regionSize  <= campRegionSize;
                        testsPerRgn <= campTestsPerRgn;
                        numRegions  <= campNumRegions;
                        rgnIdx      <= '0;
                        if (campNumRegions == '0 || campRegionSize == '0) begin
                            state <= ST_REPORT;
                        end else begin
                            state       <= ST_ISSUE;
                            configValid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cfgXfer) begin
                        configValid <= 1'b0;
                        statusStop  <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (stXfer) begin
                        stErr      <= statusErrorCount;
                        stData     <= statusDataCount;
                        statusStop <= 1'b1;
                        state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    rgnIdx  <= rgnNext;
                    curAddr <= curAddr + {32'h0, regionSize};
                    if (rgnNext == numRegions || (StopOnError && stErr != '0)) begin
                        state    <= ST_REPORT;
                        resValid <= 1'b1;
                    end else begin
                        state       <= ST_ISSUE;
                        configValid <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    // An empty campaign arrives with resValid low; it is raised a
                    // cycle later so its latency matches a pass through ACCUM.
                    if (!resValid) begin
                        resValid <= 1'b1;
                    end else if (resXfer) begin
                        resValid <= 1'b0;
                        campStop <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    campStop    <= 1'b0;
                    configValid <= 1'b0;
                    statusStop  <= 1'b1;
                    resValid    <= 1'b0;
                end
            endcase
        end
    end

endmodule
